// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_pkg                                                      |
// | Description : Shared constants and types for the frame scheduler that      |
// |               time-multiplexes one 1024-point xfft core between channels.  |
// |               FRAME_LEN    - samples per frame (power of two)              |
// |               SCALE_SCH    - xfft scaling schedule                         |
// |               FFT_CFG_WORD - {3'b0, SCALE_SCH, forward=1}                  |
// |               sched_state_t, chan_id_t                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_pkg;

   localparam int          FRAME_LEN    = 1024;
   localparam logic [19:0] SCALE_SCH    = 20'b0101_0101_0101_0101_0110;
   localparam logic [23:0] FFT_CFG_WORD = {3'b000, SCALE_SCH, 1'b1};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONFIG = 2'd1,
      STREAM = 2'd2
   } sched_state_t;

   // Wide enough for the largest supported channel count (8).
   typedef logic [2:0] chan_id_t;

endpackage
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tag_fifo                                                     |
// | Description : Synchronous FIFO holding the channel ids of frames that are  |
// |               inside the FFT core. Push and pop in one cycle are both      |
// |               honoured (also when full); pop on empty is ignored.          |
// | Ports       : clk, reset (sync, active-high)                               |
// |               push/din   - enqueue a tag                                   |
// |               pop        - dequeue the head tag                            |
// |               dout       - head tag (valid when !empty)                    |
// |               empty/full - occupancy flags                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tag_fifo #(
   parameter int DEPTH = 4,   // power of two, >= 2
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [c_AW:0]    r_wr_ptr;
   logic [c_AW:0]    r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/fft_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_frame_scheduler                                          |
// | Description : Grants one shared xfft core to NUM_CH sample streams, one    |
// |               whole frame at a time, round-robin. Issues the per-frame     |
// |               config word, generates tlast, and tags each output spectrum  |
// |               with the channel it came from.                               |
// | Ports       : clk, reset (sync, active-high)                               |
// |               s_tdata/s_tvalid/s_tready   - per-channel sample AXIS in     |
// |               fft_tdata/tvalid/tlast/tready - core s_axis_data             |
// |               cfg_tdata/cfg_tvalid/cfg_tready - core s_axis_config         |
// |               core_tlast, core_hs          - core output beat info         |
// |               m_tuser, m_tuser_valid       - channel of current spectrum   |
// |               tlast_err -> err_sticky      - latched core framing error    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_frame_scheduler #(
   parameter int          NUM_CH    = 2,
   parameter int          DATA_W    = 24,
   parameter int          FRAME_LEN = fft_pkg::FRAME_LEN,
   parameter logic [19:0] SCALE_SCH = fft_pkg::SCALE_SCH,
   parameter int          TAG_DEPTH = 4,
   localparam int         c_TUSER_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH*DATA_W-1:0] s_tdata,
   input  logic [NUM_CH-1:0]        s_tvalid,
   output logic [NUM_CH-1:0]        s_tready,
   output logic [2*DATA_W-1:0]      fft_tdata,
   output logic                     fft_tvalid,
   output logic                     fft_tlast,
   input  logic                     fft_tready,
   output logic [23:0]              cfg_tdata,
   output logic                     cfg_tvalid,
   input  logic                     cfg_tready,
   input  logic                     core_tlast,
   input  logic                     core_hs,
   output logic [c_TUSER_W-1:0]     m_tuser,
   output logic                     m_tuser_valid,
   input  logic                     tlast_err,
   output logic                     err_sticky
);

   import fft_pkg::*;

   localparam int c_CNT_W = $clog2(FRAME_LEN);

   sched_state_t          r_state;
   sched_state_t          w_state_nxt;
   logic [c_TUSER_W-1:0]  r_rr_ptr;
   logic [c_TUSER_W-1:0]  r_grant;
   logic [c_CNT_W-1:0]    r_sample_cnt;
   logic                  r_err;
   logic [c_TUSER_W:0]    w_pick;        // {found, channel id}
   logic [DATA_W-1:0]     w_sample;
   logic                  w_push;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic                  w_fft_hs;

   // First requester at or after ptr, wrapping. Scanning from the farthest
   // offset down lets the nearest requester overwrite the result last.
   function automatic logic [c_TUSER_W:0] f_rr_pick(
      input logic [NUM_CH-1:0]    req,
      input logic [c_TUSER_W-1:0] ptr
   );
      int idx;
      f_rr_pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[c_TUSER_W'(idx)]) f_rr_pick = {1'b1, c_TUSER_W'(idx)};
      end
   endfunction

   assign w_pick    = f_rr_pick(s_tvalid, r_rr_ptr);
   assign cfg_tdata = {3'b000, SCALE_SCH, 1'b1};
   assign fft_tdata = {{DATA_W{1'b0}}, w_sample};
   assign w_fft_hs  = fft_tvalid && fft_tready;
   assign err_sticky    = r_err;
   assign m_tuser_valid = !w_fifo_empty;

   always_comb begin
      w_sample = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant == c_TUSER_W'(i)) w_sample = s_tdata[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_sample_cnt <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= r_err | tlast_err;
         if (w_push) r_grant <= w_pick[c_TUSER_W-1:0];
         if (w_fft_hs) begin
            r_sample_cnt <= fft_tlast ? '0 : r_sample_cnt + 1'b1;
            // Priority only moves when a frame completes.
            if (fft_tlast)
               r_rr_ptr <= (r_grant == c_TUSER_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      cfg_tvalid  = 1'b0;
      fft_tvalid  = 1'b0;
      fft_tlast   = 1'b0;
      s_tready    = '0;
      unique case (r_state)
         IDLE: begin
            // Full tag FIFO blocks grants so every frame in flight has a tag.
            if (w_pick[c_TUSER_W] && !w_fifo_full) begin
               w_push      = 1'b1;
               w_state_nxt = CONFIG;
            end
         end
         CONFIG: begin
            cfg_tvalid = 1'b1;
            if (cfg_tready) w_state_nxt = STREAM;
         end
         STREAM: begin
            // Zero-latency pass-through; the granted channel keeps the core
            // for the whole frame even if its valid drops.
            fft_tvalid        = s_tvalid[r_grant];
            s_tready[r_grant] = fft_tready;
            fft_tlast         = (r_sample_cnt == c_CNT_W'(FRAME_LEN - 1));
            if (fft_tvalid && fft_tready && fft_tlast) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .WIDTH (c_TUSER_W)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (w_pick[c_TUSER_W-1:0]),
      .pop   (core_hs && core_tlast),
      .dout  (m_tuser),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

endmodule
`default_nettype wire
